// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the I/D requester pairs and the shared downstream port.
// slave modport is the arbiter side; master modport is the environment side.
interface mem_bus_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   localparam int unsigned SW = DW / 8;

   logic          i_valid;
   logic [AW-1:0] i_addr;
   logic          i_addr_ok;
   logic          i_data_ok;
   logic [DW-1:0] i_rdata;

   logic          d_valid;
   logic [AW-1:0] d_addr;
   logic [2:0]    d_size;
   logic [SW-1:0] d_strobe;
   logic [DW-1:0] d_wdata;
   logic          d_addr_ok;
   logic          d_data_ok;
   logic [DW-1:0] d_rdata;

   logic          m_valid;
   logic [AW-1:0] m_addr;
   logic [2:0]    m_size;
   logic [SW-1:0] m_strobe;
   logic [DW-1:0] m_wdata;
   logic          m_addr_ok;
   logic          m_data_ok;
   logic [DW-1:0] m_rdata;

   logic          busy;

   modport slave (
      input  i_valid, i_addr,
      output i_addr_ok, i_data_ok, i_rdata,
      input  d_valid, d_addr, d_size, d_strobe, d_wdata,
      output d_addr_ok, d_data_ok, d_rdata,
      output m_valid, m_addr, m_size, m_strobe, m_wdata,
      input  m_addr_ok, m_data_ok, m_rdata,
      output busy
   );

   modport master (
      output i_valid, i_addr,
      input  i_addr_ok, i_data_ok, i_rdata,
      output d_valid, d_addr, d_size, d_strobe, d_wdata,
      input  d_addr_ok, d_data_ok, d_rdata,
      input  m_valid, m_addr, m_size, m_strobe, m_wdata,
      output m_addr_ok, m_data_ok, m_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between instruction fetch (I) and data (D)
// requesters, one outstanding transaction at a time. The grant is held until the
// downstream data_ok returns; arbitration only happens in IDLE.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on collision instead of
// fixed D-over-I priority.
module mem_bus_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input logic              clk,
   input logic              resetn,
   mem_bus_arbiter_if.slave bus
);
   localparam int unsigned SW = DW / 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_I  = 3'd1,
      REQ_D  = 3'd2,
      WAIT_I = 3'd3,
      WAIT_D = 3'd4
   } state_t;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [2:0]    size_q;
   logic [SW-1:0] strobe_q;
   logic [DW-1:0] wdata_q;

   logic grant_d;
   logic grant_i;
   logic issue;
   logic accept_i;
   logic accept_d;
   logic done_i;
   logic done_d;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 when D won the most recent arbitration; reset value means I won last
   logic last_d;

   assign grant_d = bus.d_valid & (~bus.i_valid | ~last_d);

   // Remember the winner of every IDLE->REQ transition
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_d <= 1'b0;
      end else if (state == IDLE) begin
         if (grant_d) begin
            last_d <= 1'b1;
         end else if (grant_i) begin
            last_d <= 1'b0;
         end
      end
   end
`else
   // Fixed priority: the older memory-stage op always wins
   assign grant_d = bus.d_valid;
`endif

   assign grant_i = bus.i_valid & ~grant_d;

   // Request phase and completion decode
   assign issue    = (state == REQ_I) | (state == REQ_D);
   assign accept_i = (state == REQ_I) & bus.m_addr_ok;
   assign accept_d = (state == REQ_D) & bus.m_addr_ok;
   assign done_i   = (accept_i | (state == WAIT_I)) & bus.m_data_ok;
   assign done_d   = (accept_d | (state == WAIT_D)) & bus.m_data_ok;

   // Arbitration, payload latch and transaction progress
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         addr_q   <= '0;
         size_q   <= 3'd0;
         strobe_q <= '0;
         wdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state    <= REQ_D;
                  addr_q   <= bus.d_addr;
                  size_q   <= bus.d_size;
                  strobe_q <= bus.d_strobe;
                  wdata_q  <= bus.d_wdata;
               end else if (grant_i) begin
                  state    <= REQ_I;
                  addr_q   <= bus.i_addr;
                  size_q   <= 3'd2;
                  strobe_q <= '0;
                  wdata_q  <= '0;
               end
            end
            REQ_I: begin
               if (bus.m_addr_ok) begin
                  state <= bus.m_data_ok ? IDLE : WAIT_I;
               end
            end
            REQ_D: begin
               if (bus.m_addr_ok) begin
                  state <= bus.m_data_ok ? IDLE : WAIT_D;
               end
            end
            WAIT_I: begin
               if (bus.m_data_ok) begin
                  state <= IDLE;
               end
            end
            WAIT_D: begin
               if (bus.m_data_ok) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Downstream request, zeroed whenever no request is being presented
   assign bus.m_valid  = issue;
   assign bus.m_addr   = issue ? addr_q   : '0;
   assign bus.m_size   = issue ? size_q   : 3'd0;
   assign bus.m_strobe = issue ? strobe_q : '0;
   assign bus.m_wdata  = issue ? wdata_q  : '0;

   // Responses routed only to the owner; data gated by data_ok
   assign bus.i_addr_ok = accept_i;
   assign bus.d_addr_ok = accept_d;
   assign bus.i_data_ok = done_i;
   assign bus.d_data_ok = done_d;
   assign bus.i_rdata   = done_i ? bus.m_rdata : '0;
   assign bus.d_rdata   = done_d ? bus.m_rdata : '0;

   assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model of requesters,
// arbiter and memory pushes expected downstream requests and responses; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_bus_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int PH_FREE  = 0;
   localparam int PH_ISSUE = 1;
   localparam int PH_WAIT  = 2;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   typedef struct {
      bit            is_d;
      logic [AW-1:0] addr;
      logic [2:0]    size;
      logic [SW-1:0] strobe;
      logic [DW-1:0] wdata;
   } req_t;
   typedef struct {
      bit            is_d;
      logic [DW-1:0] rdata;
   } rsp_t;

   req_t exp_req[$];
   rsp_t exp_rsp[$];

   int errors = 0;
   int checks = 0;

   // transaction-level model state
   int phase = PH_FREE;
   bit owner_d = 1'b0;
   bit last_d = 1'b0;
   int lat = 0;
   bit i_act = 1'b0;
   bit d_act = 1'b0;
   bit exp_busy = 1'b0;
   bit exp_mvalid = 1'b0;
   bit chk_en = 1'b0;
   int i_acc = 0;
   int d_acc = 0;

   // stimulus knobs
   int i_pct, d_pct, addr_pct, same_pct, lat_min, lat_max, drop_pct, noise_pct;
   bit fixed_en;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit pct(input int p);
      return int'($urandom_range(99, 0)) < p;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_i_addr_ok"}, 64'(bus.i_addr_ok), 64'(0));
      chk({tag, "_i_data_ok"}, 64'(bus.i_data_ok), 64'(0));
      chk({tag, "_i_rdata"},   64'(bus.i_rdata),   64'(0));
      chk({tag, "_d_addr_ok"}, 64'(bus.d_addr_ok), 64'(0));
      chk({tag, "_d_data_ok"}, 64'(bus.d_data_ok), 64'(0));
      chk({tag, "_d_rdata"},   64'(bus.d_rdata),   64'(0));
      chk({tag, "_m_valid"},   64'(bus.m_valid),   64'(0));
      chk({tag, "_m_addr"},    64'(bus.m_addr),    64'(0));
      chk({tag, "_m_size"},    64'(bus.m_size),    64'(0));
      chk({tag, "_m_strobe"},  64'(bus.m_strobe),  64'(0));
      chk({tag, "_m_wdata"},   64'(bus.m_wdata),   64'(0));
      chk({tag, "_busy"},      64'(bus.busy),      64'(0));
   endtask

   // One clock of requester stimulus, memory behaviour and reference model
   task automatic drive_cycle();
      bit   aok;
      bit   dok;
      bit   win_d;
      req_t r;
      // fetch requester
      if (!i_act) begin
         bus.i_addr  = fixed_en ? 32'hBFC0_0000 : $urandom();
         bus.i_valid = pct(i_pct);
         i_act       = bus.i_valid;
      end else if (phase != PH_FREE && !owner_d) begin
         bus.i_addr = $urandom();
         if (phase == PH_WAIT && pct(drop_pct)) bus.i_valid = 1'b0;
      end
      // data requester
      if (!d_act) begin
         bus.d_addr   = fixed_en ? 32'h8000_1000 : $urandom();
         bus.d_size   = fixed_en ? 3'd2 : 3'($urandom_range(7, 0));
         bus.d_strobe = fixed_en ? 4'b0011 : (pct(50) ? SW'($urandom()) : '0);
         bus.d_wdata  = fixed_en ? 32'h0000_1234 : $urandom();
         bus.d_valid  = pct(d_pct);
         d_act        = bus.d_valid;
      end else if (phase != PH_FREE && owner_d) begin
         bus.d_addr   = $urandom();
         bus.d_strobe = SW'($urandom());
         bus.d_wdata  = $urandom();
         if (phase == PH_WAIT && pct(drop_pct)) bus.d_valid = 1'b0;
      end
      // memory: accept, respond, or inject ignored noise
      aok = 1'b0;
      dok = 1'b0;
      if (phase == PH_ISSUE) begin
         aok = pct(addr_pct);
         if (aok) dok = pct(same_pct);
      end else if (phase == PH_WAIT) begin
         if (lat == 0) dok = 1'b1;
         else lat--;
      end
      bus.m_addr_ok = aok | (phase != PH_ISSUE && pct(noise_pct));
      bus.m_data_ok = dok | (phase != PH_WAIT && !aok && pct(noise_pct));
      bus.m_rdata   = fixed_en ? 32'h3C08_0001 : $urandom();
      exp_busy   = (phase != PH_FREE);
      exp_mvalid = (phase == PH_ISSUE);
      if (dok) exp_rsp.push_back('{is_d: owner_d, rdata: bus.m_rdata});
      // advance the model to the next cycle
      case (phase)
         PH_FREE: begin
            if (bus.i_valid || bus.d_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
               win_d = bus.d_valid && (!bus.i_valid || !last_d);
`else
               win_d = bus.d_valid;
`endif
               if (win_d)
                  r = '{is_d: 1'b1, addr: bus.d_addr, size: bus.d_size,
                        strobe: bus.d_strobe, wdata: bus.d_wdata};
               else
                  r = '{is_d: 1'b0, addr: bus.i_addr, size: 3'd2, strobe: '0, wdata: '0};
               exp_req.push_back(r);
               owner_d = win_d;
               last_d  = win_d;
               phase   = PH_ISSUE;
            end
         end
         PH_ISSUE: begin
            if (aok && !dok) begin
               phase = PH_WAIT;
               lat   = int'($urandom_range(lat_max, lat_min));
            end
         end
         default: ;
      endcase
      if (dok) begin
         phase = PH_FREE;
         if (owner_d) d_act = 1'b0;
         else i_act = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_knobs(input int ip, input int dp, input int ap, input int sp,
                            input int lmin, input int lmax, input int drp, input int np,
                            input bit fx);
      i_pct = ip; d_pct = dp; addr_pct = ap; same_pct = sp;
      lat_min = lmin; lat_max = lmax; drop_pct = drp; noise_pct = np; fixed_en = fx;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) drive_cycle();
   endtask

   // Finish outstanding work, then require both queues to be empty
   task automatic drain();
      set_knobs(0, 0, 100, 0, 0, 1, 0, 0, 1'b0);
      for (int k = 0; k < 40 && (phase != PH_FREE || i_act || d_act); k++) drive_cycle();
      run(2);
      chk("req_queue_empty", 64'(exp_req.size()), 64'(0));
      chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'(0));
   endtask

   // Monitor: compare whatever the DUT presents against the scoreboard
   always @(negedge clk) begin : monitor
      req_t r;
      rsp_t s;
      if (chk_en) begin
         chk("busy", 64'(bus.busy), 64'(exp_busy));
         chk("m_valid", 64'(bus.m_valid), 64'(exp_mvalid));
         if (bus.m_valid && bus.m_addr_ok) begin
            chk("req_expected", 64'(exp_req.size() != 0), 64'(1));
            if (exp_req.size() != 0) begin
               r = exp_req.pop_front();
               chk("m_addr",    64'(bus.m_addr),    64'(r.addr));
               chk("m_size",    64'(bus.m_size),    64'(r.size));
               chk("m_strobe",  64'(bus.m_strobe),  64'(r.strobe));
               chk("m_wdata",   64'(bus.m_wdata),   64'(r.wdata));
               chk("i_addr_ok", 64'(bus.i_addr_ok), 64'(!r.is_d));
               chk("d_addr_ok", 64'(bus.d_addr_ok), 64'(r.is_d));
            end
            if (bus.i_addr_ok) i_acc++;
            if (bus.d_addr_ok) d_acc++;
         end else begin
            chk("addr_ok_quiet", 64'({bus.i_addr_ok, bus.d_addr_ok}), 64'(0));
         end
         if (bus.i_data_ok || bus.d_data_ok) begin
            chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
            if (exp_rsp.size() != 0) begin
               s = exp_rsp.pop_front();
               chk("i_data_ok", 64'(bus.i_data_ok), 64'(!s.is_d));
               chk("d_data_ok", 64'(bus.d_data_ok), 64'(s.is_d));
               chk("owner_rdata", 64'(s.is_d ? bus.d_rdata : bus.i_rdata), 64'(s.rdata));
               chk("other_rdata", 64'(s.is_d ? bus.i_rdata : bus.d_rdata), 64'(0));
            end
         end else begin
            chk("rdata_gated", 64'({bus.i_rdata, bus.d_rdata}), 64'(0));
         end
      end
   end

   initial begin
      bus.i_valid = 1'b0; bus.i_addr = '0;
      bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_size = 3'd0;
      bus.d_strobe = '0; bus.d_wdata = '0;
      bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = '0;
      set_knobs(0, 0, 100, 0, 0, 1, 0, 0, 1'b0);
      resetn = 1'b0;
      #12;
      chk_all_zero("reset");
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // fetch only: accept in one cycle, data two cycles after accept
      set_knobs(100, 0, 100, 0, 1, 1, 0, 0, 1'b1);
      run(12);
      drain();

      // store only, accept and data in the same cycle
      set_knobs(0, 100, 100, 100, 0, 0, 0, 0, 1'b1);
      run(12);
      drain();

      // both requesters always valid: collision arbitration
      i_acc = 0;
      d_acc = 0;
      set_knobs(100, 100, 100, 0, 0, 1, 0, 0, 1'b0);
      run(30);
`ifdef ARB_ROUND_ROBIN_EN
      chk("rr_balance", 64'((i_acc > d_acc ? i_acc - d_acc : d_acc - i_acc) <= 1), 64'(1));
      chk("rr_d_grants", 64'(d_acc >= 3), 64'(1));
`else
      chk("fixed_i_grants", 64'(i_acc), 64'(0));
      chk("fixed_d_grants", 64'(d_acc >= 3), 64'(1));
`endif
      drain();

      // fetch valid dropped while waiting for data
      set_knobs(100, 0, 100, 0, 2, 3, 100, 0, 1'b0);
      run(20);
      drain();

      // randomized mix with protocol noise on the downstream handshakes
      set_knobs(40, 40, 60, 25, 0, 3, 20, 20, 1'b0);
      run(2000);
      drain();

      // reset asserted while a store waits for its data
      set_knobs(0, 100, 100, 0, 6, 6, 0, 0, 1'b0);
      for (int k = 0; k < 20 && phase != PH_WAIT; k++) drive_cycle();
      chk("reached_wait_d", 64'(phase == PH_WAIT && owner_d), 64'(1));
      chk_en = 1'b0;
      #2 resetn = 1'b0;
      #1 chk_all_zero("rst_mid");
      bus.i_valid = 1'b0; bus.d_valid = 1'b0;
      bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0;
      exp_req.delete();
      exp_rsp.delete();
      phase = PH_FREE; i_act = 1'b0; d_act = 1'b0; last_d = 1'b0;
      exp_busy = 1'b0; exp_mvalid = 1'b0;
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_busy", 64'(bus.busy), 64'(0));
      chk_en = 1'b1;
      set_knobs(60, 60, 70, 30, 0, 2, 0, 0, 1'b0);
      run(40);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
